ins_encoder: RTL

//  Inverse of the instruction decoder: turns decoded fields (type, rd, rs1, rs2, imm) into RV32I 32-bit codes.

---
 rtl/ins_encoder.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ins_encoder.sv
// ins_encoder: packs decoded RV32I fields back into 32-bit instruction words.
// One input register stage (S1) feeds a DEPTH-entry output FIFO. Both sides use
// valid/ready. Fields that fail their range check become a NOP flagged by out_err.

// Opcode enumeration and register-number width shared with the decoder. When the
// decoder's define.v is compiled first, its values take precedence over these.
`ifndef OPE_WIDTH
`define OPE_WIDTH 6
`define LUI       6'd0
`define AUIPC     6'd1
`define JAL       6'd2
`define JALR      6'd3
`define BEQ       6'd4
`define BNE       6'd5
`define BLT       6'd6
`define BGE       6'd7
`define BLTU      6'd8
`define BGEU      6'd9
`define LB        6'd10
`define LH        6'd11
`define LW        6'd12
`define LBU       6'd13
`define LHU       6'd14
`define SB        6'd15
`define SH        6'd16
`define SW        6'd17
`define ADDI      6'd18
`define SLTI      6'd19
`define SLTIU     6'd20
`define XORI      6'd21
`define ORI       6'd22
`define ANDI      6'd23
`define SLLI      6'd24
`define SRLI      6'd25
`define SRAI      6'd26
`define ADD       6'd27
`define SUB       6'd28
`define SLL       6'd29
`define SLT       6'd30
`define SLTU      6'd31
`define XOR       6'd32
`define SRL       6'd33
`define SRA       6'd34
`define OR        6'd35
`define AND       6'd36
`define EMPTY_INS 6'd37
`endif

`ifndef REG_NUMBER_WIDTH
`define REG_NUMBER_WIDTH 6
`define REG_NUMBER       6'd32
`endif

module ins_encoder #(
  parameter int DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [`OPE_WIDTH-1:0]        ins_type,
  input  logic [`REG_NUMBER_WIDTH-1:0] ins_rd,
  input  logic [`REG_NUMBER_WIDTH-1:0] ins_rs1,
  input  logic [`REG_NUMBER_WIDTH-1:0] ins_rs2,
  input  logic [31:0]                  ins_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_code,
  output logic                         out_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_REG   = 7'h33;

  localparam logic [2:0] FMT_BAD = 3'd0;
  localparam logic [2:0] FMT_U   = 3'd1;
  localparam logic [2:0] FMT_J   = 3'd2;
  localparam logic [2:0] FMT_I   = 3'd3;
  localparam logic [2:0] FMT_SH  = 3'd4;
  localparam logic [2:0] FMT_B   = 3'd5;
  localparam logic [2:0] FMT_S   = 3'd6;
  localparam logic [2:0] FMT_R   = 3'd7;

  // Register numbers of 32 and above mean "field unused" and encode as x0.
  // The register-number width is at least 6, so 32 is representable.
  function automatic logic [4:0] reg_field(input logic [`REG_NUMBER_WIDTH-1:0] r);
    return (r < `REG_NUMBER_WIDTH'(32)) ? r[4:0] : 5'd0;
  endfunction

  // Returns {err, code}. Illegal input yields {1, NOP}.
  function automatic logic [32:0] encode(
    input logic [`OPE_WIDTH-1:0]        t,
    input logic [`REG_NUMBER_WIDTH-1:0] rd_n,
    input logic [`REG_NUMBER_WIDTH-1:0] rs1_n,
    input logic [`REG_NUMBER_WIDTH-1:0] rs2_n,
    input logic [31:0]                  imm
  );
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic        b30;
    logic        legal;
    logic [31:0] code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    fmt   = FMT_BAD;
    f3    = 3'd0;
    op    = OP_IMM;
    b30   = 1'b0;
    legal = 1'b0;
    code  = NOP;
    rd    = reg_field(rd_n);
    rs1   = reg_field(rs1_n);
    rs2   = reg_field(rs2_n);
    case (t)
      `LUI:   begin fmt = FMT_U;  op = OP_LUI;   end
      `AUIPC: begin fmt = FMT_U;  op = OP_AUIPC; end
      `JAL:   begin fmt = FMT_J;  op = OP_JAL;   end
      `JALR:  begin fmt = FMT_I;  op = OP_JALR;  f3 = 3'd0; end
      `BEQ:   begin fmt = FMT_B;  op = OP_BR;    f3 = 3'd0; end
      `BNE:   begin fmt = FMT_B;  op = OP_BR;    f3 = 3'd1; end
      `BLT:   begin fmt = FMT_B;  op = OP_BR;    f3 = 3'd4; end
      `BGE:   begin fmt = FMT_B;  op = OP_BR;    f3 = 3'd5; end
      `BLTU:  begin fmt = FMT_B;  op = OP_BR;    f3 = 3'd6; end
      `BGEU:  begin fmt = FMT_B;  op = OP_BR;    f3 = 3'd7; end
      `LB:    begin fmt = FMT_I;  op = OP_LOAD;  f3 = 3'd0; end
      `LH:    begin fmt = FMT_I;  op = OP_LOAD;  f3 = 3'd1; end
      `LW:    begin fmt = FMT_I;  op = OP_LOAD;  f3 = 3'd2; end
      `LBU:   begin fmt = FMT_I;  op = OP_LOAD;  f3 = 3'd4; end
      `LHU:   begin fmt = FMT_I;  op = OP_LOAD;  f3 = 3'd5; end
      `SB:    begin fmt = FMT_S;  op = OP_ST;    f3 = 3'd0; end
      `SH:    begin fmt = FMT_S;  op = OP_ST;    f3 = 3'd1; end
      `SW:    begin fmt = FMT_S;  op = OP_ST;    f3 = 3'd2; end
      `ADDI:  begin fmt = FMT_I;  op = OP_IMM;   f3 = 3'd0; end
      `SLTI:  begin fmt = FMT_I;  op = OP_IMM;   f3 = 3'd2; end
      `SLTIU: begin fmt = FMT_I;  op = OP_IMM;   f3 = 3'd3; end
      `XORI:  begin fmt = FMT_I;  op = OP_IMM;   f3 = 3'd4; end
      `ORI:   begin fmt = FMT_I;  op = OP_IMM;   f3 = 3'd6; end
      `ANDI:  begin fmt = FMT_I;  op = OP_IMM;   f3 = 3'd7; end
      `SLLI:  begin fmt = FMT_SH; op = OP_IMM;   f3 = 3'd1; end
      `SRLI:  begin fmt = FMT_SH; op = OP_IMM;   f3 = 3'd5; end
      `SRAI:  begin fmt = FMT_SH; op = OP_IMM;   f3 = 3'd5; b30 = 1'b1; end
      `ADD:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd0; end
      `SUB:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd0; b30 = 1'b1; end
      `SLL:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd1; end
      `SLT:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd2; end
      `SLTU:  begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd3; end
      `XOR:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd4; end
      `SRL:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd5; end
      `SRA:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd5; b30 = 1'b1; end
      `OR:    begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd6; end
      `AND:   begin fmt = FMT_R;  op = OP_REG;   f3 = 3'd7; end
      default: fmt = FMT_BAD;
    endcase
    // Range checks: an immediate fits N signed bits when bits [31:N-1] are all equal.
    case (fmt)
      FMT_U: begin
        legal = (imm[11:0] == 12'd0);
        code  = {imm[31:12], rd, op};
      end
      FMT_J: begin
        legal = !imm[0] && ((&imm[31:20]) || !(|imm[31:20]));
        code  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      FMT_I: begin
        legal = (&imm[31:11]) || !(|imm[31:11]);
        code  = {imm[11:0], rs1, f3, rd, op};
      end
      FMT_SH: begin
        legal = !(|imm[31:5]);
        code  = {1'b0, b30, 5'd0, imm[4:0], rs1, f3, rd, op};
      end
      FMT_B: begin
        legal = !imm[0] && ((&imm[31:12]) || !(|imm[31:12]));
        code  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      FMT_S: begin
        legal = (&imm[31:11]) || !(|imm[31:11]);
        code  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      FMT_R: begin
        legal = 1'b1;
        code  = {1'b0, b30, 5'd0, rs2, rs1, f3, rd, op};
      end
      default: legal = 1'b0;
    endcase
    return legal ? {1'b0, code} : {1'b1, NOP};
  endfunction

  logic                         r_vld_p1;
  logic [`OPE_WIDTH-1:0]        r_type_p1;
  logic [`REG_NUMBER_WIDTH-1:0] r_rd_p1;
  logic [`REG_NUMBER_WIDTH-1:0] r_rs1_p1;
  logic [`REG_NUMBER_WIDTH-1:0] r_rs2_p1;
  logic [31:0]                  r_imm_p1;

  logic [31:0]   r_mem_code [DEPTH];
  logic          r_mem_err  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_hold_code;
  logic          r_hold_err;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_has_room;
  logic [32:0]   w_enc;

  // The room check uses the current count only: a pop in the same cycle does not
  // make space for S1 until the following cycle.
  assign w_has_room = (r_count < CW'(DEPTH));
  assign in_ready   = !r_vld_p1 || w_has_room;
  assign w_accept   = in_valid && in_ready;
  assign w_push     = r_vld_p1 && w_has_room;
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_enc      = encode(r_type_p1, r_rd_p1, r_rs1_p1, r_rs2_p1, r_imm_p1);

  // While the FIFO is empty the outputs repeat the last head that was presented.
  assign out_code = out_valid ? r_mem_code[r_rd_ptr] : r_hold_code;
  assign out_err  = out_valid ? r_mem_err[r_rd_ptr]  : r_hold_err;

  // Stage S1 -> FIFO: control state (valid flag, pointers, count, held head).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vld_p1    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hold_code <= 32'd0;
      r_hold_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vld_p1 <= 1'b1;
      end else if (w_push) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (out_valid) begin
        r_hold_code <= r_mem_code[r_rd_ptr];
        r_hold_err  <= r_mem_err[r_rd_ptr];
      end
    end
  end

  // Input -> stage S1: capture raw fields; encoding happens combinationally from S1.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_type_p1 <= ins_type;
      r_rd_p1   <= ins_rd;
      r_rs1_p1  <= ins_rs1;
      r_rs2_p1  <= ins_rs2;
      r_imm_p1  <= ins_imm;
    end
  end

  // Stage S1 -> FIFO storage: write encoded word and error flag at the tail.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem_code[r_wr_ptr] <= w_enc[31:0];
      r_mem_err[r_wr_ptr]  <= w_enc[32];
    end
  end

endmodule
